// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM states and the restoring-divide step for the mul/div controller.
package muldiv_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MUL   = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8
    } md_op_e;

    typedef enum logic [2:0] {
        MDS_IDLE,
        MDS_MUL_BUSY,
        MDS_DIV_BUSY,
        MDS_DIV_FIX,
        MDS_DONE
    } md_state_e;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_pair_t;

    function automatic logic md_known(input logic [3:0] op);
        return op <= MD_MSUBU;
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MUL) ||
               (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    // One restoring step: shift {rem,quo} left, keep the trial difference when it does not borrow.
    function automatic div_pair_t div_step(input div_pair_t p, input logic [31:0] dvs);
        div_pair_t   r;
        logic [32:0] sh;
        logic [32:0] diff;
        sh    = {p.rem, p.quo[31]};
        diff  = sh - {1'b0, dvs};
        r.quo = {p.quo[30:0], ~diff[32]};
        r.rem = diff[32] ? sh[31:0] : diff[31:0];
        return r;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Iterative radix-2 restoring divider on magnitudes; the first step happens on load.
module div_radix2
    import muldiv_ctrl_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        abort_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o,
    output logic        done_o
);
    localparam int CW = $clog2(DIV_ITER + 1);

    div_pair_t   pair_q, pair_d, pair_init;
    logic [31:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        pair_init.rem = '0;
        pair_init.quo = dividend_i;
        pair_d = pair_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (load_i) begin
            pair_d = div_step(pair_init, divisor_i);
            dvs_d  = divisor_i;
            cnt_d  = CW'(DIV_ITER - 1);
            busy_d = (DIV_ITER > 1);
        end else if (busy_q) begin
            pair_d = div_step(pair_q, dvs_q);
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            pair_q <= pair_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // High in the cycle that performs the final step.
    assign done_o = busy_q && (cnt_q == CW'(1));
    assign rem_o  = pair_q.rem;
    assign quo_o  = pair_q.quo;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: stalls EX, produces HI/LO or the MUL GPR result.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [63:0] hilo_in,
    input  logic        flush,
    input  logic        stall_mem,
    output logic        stall_ex,
    output logic [63:0] hilo_out,
    output logic        hilo_wen,
    output logic [31:0] mul_out,
    output logic        mul_valid
);
    localparam int MCW = $clog2(MUL_LAT + 1);

    md_state_e   state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [63:0] h_q;
    logic        sa_q, sb_q;
    logic [MCW-1:0] cnt_q, cnt_d;
    logic [63:0] hilo_q, hilo_d;
    logic [31:0] mulo_q, mulo_d;
    logic        cap_en, div_load, div_abort, div_done, accept;
    logic        sa_in, sb_in;
    logic [31:0] div_rem, div_quo, quo_fix, rem_fix;

    // Multiplier reads the live inputs in IDLE so a single-stage pipe can finish on the accept edge.
    logic [3:0]  m_op;
    logic [31:0] ma, mb;
    logic [63:0] mh, ea, eb, prod, acc;

    always_comb begin
        m_op = (state_q == MDS_IDLE) ? op      : op_q;
        ma   = (state_q == MDS_IDLE) ? src_a   : a_q;
        mb   = (state_q == MDS_IDLE) ? src_b   : b_q;
        mh   = (state_q == MDS_IDLE) ? hilo_in : h_q;
        ea   = md_is_signed(m_op) ? {{32{ma[31]}}, ma} : {32'b0, ma};
        eb   = md_is_signed(m_op) ? {{32{mb[31]}}, mb} : {32'b0, mb};
        prod = ea * eb;
        if (m_op == MD_MADD || m_op == MD_MADDU)      acc = mh + prod;
        else if (m_op == MD_MSUB || m_op == MD_MSUBU) acc = mh - prod;
        else                                          acc = prod;
    end

    assign accept  = start && !flush && md_known(op);
    assign sa_in   = md_is_signed(op) && src_a[31];
    assign sb_in   = md_is_signed(op) && src_b[31];
    assign quo_fix = (sa_q ^ sb_q) ? -div_quo : div_quo;
    assign rem_fix = sa_q ? -div_rem : div_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hilo_d    = hilo_q;
        mulo_d    = mulo_q;
        cap_en    = 1'b0;
        div_load  = 1'b0;
        div_abort = 1'b0;
        hilo_wen  = 1'b0;
        mul_valid = 1'b0;
        case (state_q)
            MDS_IDLE: begin
                if (accept) begin
                    cap_en = 1'b1;
                    if (md_is_div(op)) begin
                        div_load = 1'b1;
                        state_d  = (DIV_ITER == 1) ? MDS_DIV_FIX : MDS_DIV_BUSY;
                    end else if (MUL_LAT == 1) begin
                        state_d = MDS_DONE;
                        if (m_op == MD_MUL) mulo_d = prod[31:0];
                        else                hilo_d = acc;
                    end else begin
                        state_d = MDS_MUL_BUSY;
                        cnt_d   = MCW'(MUL_LAT - 1);
                    end
                end
            end
            MDS_MUL_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == MCW'(1)) begin
                    state_d = MDS_DONE;
                    if (m_op == MD_MUL) mulo_d = prod[31:0];
                    else                hilo_d = acc;
                end
            end
            MDS_DIV_BUSY: begin
                if (div_done) state_d = MDS_DIV_FIX;
            end
            MDS_DIV_FIX: begin
                hilo_d  = {rem_fix, quo_fix};
                state_d = MDS_DONE;
            end
            MDS_DONE: begin
                if (!stall_mem) begin
                    hilo_wen  = (op_q != MD_MUL);
                    mul_valid = (op_q == MD_MUL);
                    state_d   = MDS_IDLE;
                end
            end
            default: state_d = MDS_IDLE;
        endcase
        // Flush kills the op outright: no strobe, no result update.
        if (flush && state_q != MDS_IDLE) begin
            state_d   = MDS_IDLE;
            cnt_d     = '0;
            hilo_d    = hilo_q;
            mulo_d    = mulo_q;
            div_abort = 1'b1;
            hilo_wen  = 1'b0;
            mul_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDS_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            h_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            hilo_q  <= '0;
            mulo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hilo_q  <= hilo_d;
            mulo_q  <= mulo_d;
            if (cap_en) begin
                op_q <= op;
                a_q  <= src_a;
                b_q  <= src_b;
                h_q  <= hilo_in;
                sa_q <= sa_in;
                sb_q <= sb_in;
            end
        end
    end

    div_radix2 #(.DIV_ITER(DIV_ITER)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (div_load),
        .abort_i    (div_abort),
        .dividend_i (sa_in ? -src_a : src_a),
        .divisor_i  (sb_in ? -src_b : src_b),
        .rem_o      (div_rem),
        .quo_o      (div_quo),
        .done_o     (div_done)
    );

    assign stall_ex = (state_q != MDS_DONE) && (state_q != MDS_IDLE || accept);
    assign hilo_out = hilo_q;
    assign mul_out  = mulo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide controller in the EX stage of the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MUL/MADD/MADDU/MSUB/MSUBU from EX and sequences a pipelined multiplier and an iterative radix-2 divider.
- Stalls EX until the result is ready. Delivers a 64-bit HI/LO result, or the 32-bit GPR result for MUL.
- Aborts cleanly on pipeline flush.

Parameters:
- MUL_LAT, 2, register stages between operand capture and product ready (1..4).
- DIV_ITER, 32, divider iterations, one quotient bit per cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  EX holds a valid mul/div op (is_divD|is_multD piped to EX)
- op  in  4  op code, `MD_* encoding
- src_a  in  32  rs value
- src_b  in  32  rt value
- hilo_in  in  64  current {HI,LO}, forwarded; used by MADD/MSUB
- flush  in  1  exception/eret flush of EX
- stall_mem  in  1  downstream stall; result must be held
- stall_ex  out  1  EX must hold its instruction
- hilo_out  out  64  {HI,LO} result
- hilo_wen  out  1  write HI/LO with hilo_out
- mul_out  out  32  low word of product for MUL (GPR write)
- mul_valid  out  1  mul_out valid this cycle

Behaviour:
- States: IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX, DONE.
- Reset values: state=IDLE; all outputs 0; counters 0.
- IDLE, start=1, flush=0:
  - Capture op, src_a, src_b and hilo_in into internal registers.
  - Multiply class (MULT/MULTU/MUL/MADD*/MSUB*): go to MUL_BUSY with cnt=MUL_LAT-1.
  - DIV/DIVU: load |a|, |b| (signed ops only take abs), sign flags, rem=0; go to DIV_BUSY with cnt=DIV_ITER-1.
  - Unknown op: ignored, stays IDLE, no stall.
- stall_ex = (state!=DONE) && (state!=IDLE || (start && !flush && known op)). Combinational, so the accept cycle already stalls.
- MUL_BUSY:
  - Signed (MULT/MUL/MADD/MSUB) or unsigned 32x32 -> 64 product.
  - cnt decrements each cycle; at cnt=0 go to DONE.
  - MADD/MADDU: hilo_out = hilo_cap + prod. MSUB/MSUBU: hilo_out = hilo_cap - prod.
  - Accumulate arithmetic is mod 2^64, registered on entry to DONE.
- Multiply latency: accept cycle T, DONE at T+MUL_LAT.
- DIV_BUSY:
  - Restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor, set quotient bit when non-negative.
  - After DIV_ITER steps go to DIV_FIX.
- DIV_FIX:
  - Negate quotient if sign_a^sign_b; negate remainder if sign_a.
  - Result HI=rem, LO=quo. Go to DONE.
- Divide latency: DONE at T+DIV_ITER+1 (T+33 by default).
- Divide by zero: no trap; natural restoring result.
  - DIVU x/0: LO=0xFFFFFFFF, HI=x.
  - DIV: sign fix-up is applied to that raw result, per the same rule.
- DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DONE:
  - stall_ex=0.
  - If !stall_mem: hilo_wen=1 for all ops except MUL; mul_valid=1 for MUL only; go to IDLE next cycle.
  - If stall_mem: remain in DONE with outputs held and wen/valid low.
  - Exactly one wen/valid pulse per accepted op.
- flush in any non-IDLE state:
  - Next state IDLE; no hilo_wen/mul_valid that cycle or later for the aborted op.
  - flush overrides start in IDLE.
- start while busy: ignored; EX is stalled, so op stays presented and is not re-accepted after DONE unless still asserted next cycle in IDLE. EX advances on the DONE cycle.
- hilo_out and mul_out hold their last value when not DONE.

Decomposition:
- defines.vh gains `MD_MULT=4'd0, `MD_MULTU=1, `MD_DIV=2, `MD_DIVU=3, `MD_MUL=4, `MD_MADD=5, `MD_MADDU=6, `MD_MSUB=7, `MD_MSUBU=8.
- defines.vh also gains state encodings `MDS_IDLE..`MDS_DONE.
- One sub-module: div_radix2, which holds the iteration datapath (rem/quo shift-subtract, cnt, done flag). The FSM, multiplier pipe and accumulate stay in muldiv_ctrl.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall_ex high 2 cycles; then hilo_wen=1, hilo_out=0xFFFFFFFE_00000001.
- DIV a=7 b=0xFFFFFFFE (-2) -> stall 33 cycles; hilo_out={HI=0x00000001, LO=0xFFFFFFFD}.
- MADD hilo_in=0x00000000_00000005 a=3 b=0xFFFFFFFE -> hilo_out=0xFFFFFFFF_FFFFFFFF.
- MUL a=0x00010000 b=0x00010001 -> mul_valid=1, mul_out=0x00010000, hilo_wen=0.
- DIVU a=0x12345678 b=0 -> LO=0xFFFFFFFF, HI=0x12345678.
- DIV with flush at iteration 10 -> IDLE next cycle, no hilo_wen; a following MULT 2*3 completes with hilo_out=6.
- MULT done with stall_mem high 3 cycles -> DONE held, hilo_wen pulses once on the first cycle stall_mem=0.
